cv32e40p_instr_fifo: RTL and testbench

CV32E40P_INSTR_FIFO -- requirements
Module: cv32e40p_instr_fifo

---
 rtl/cv32e40p_pkg.sv | 18 +
 rtl/cv32e40p_instr_fifo.sv | 177 +++++++++++++++++
 tb/tb_cv32e40p_instr_fifo.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_pkg
// Shared constants and helpers for the instruction fetch path.
//   INSTR_FIFO_DEPTH           : default number of stored fetch words
//   INSTR_FIFO_MAX_OUTSTANDING : default limit on issued, unanswered bus requests
//   cnt_width()                : bits needed to hold a count of 0..n
// -----------------------------------------------------------------------------
package cv32e40p_pkg;

   localparam int INSTR_FIFO_DEPTH           = 2;
   localparam int INSTR_FIFO_MAX_OUTSTANDING = 2;

   // Width of a counter that must represent every value 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage : cv32e40p_pkg

// File: rtl/cv32e40p_instr_fifo.sv
// -----------------------------------------------------------------------------
// cv32e40p_instr_fifo
// Prefetch buffer between the instruction bus and the aligner. It tracks
// outstanding bus transactions, discards responses that belong to a stream
// abandoned by a branch, and presents words to the aligner with a zero-latency
// bypass when empty.
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   branch_i        in   branch/flush: drop buffered words and pending responses
//   trans_issued_i  in   a bus request was accepted this cycle
//   resp_valid_i    in   a bus response arrives this cycle
//   resp_rdata_i    in   response word
//   resp_err_i      in   response bus error flag
//   req_allowed_o   out  fetch controller may issue another request
//   fetch_valid_o   out  a word is presented to the aligner
//   fetch_rdata_o   out  presented word
//   fetch_err_o     out  error flag of the presented word
//   pop_i           in   aligner consumes the presented word
//
// Handshake: the word is transferred in any cycle where fetch_valid_o and
// pop_i are both 1; pop_i while fetch_valid_o is 0 has no effect. Requests may
// be issued only while req_allowed_o is 1; req_allowed_o depends on registered
// state only, so there is no combinational path from any input to it.
// -----------------------------------------------------------------------------
module cv32e40p_instr_fifo
   import cv32e40p_pkg::*;
#(
   parameter int DEPTH           = INSTR_FIFO_DEPTH,
   parameter int MAX_OUTSTANDING = INSTR_FIFO_MAX_OUTSTANDING
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_i,
   input  logic        trans_issued_i,
   input  logic        resp_valid_i,
   input  logic [31:0] resp_rdata_i,
   input  logic        resp_err_i,
   output logic        req_allowed_o,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_rdata_o,
   output logic        fetch_err_o,
   input  logic        pop_i
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = cnt_width(DEPTH);
   localparam int OUT_W = cnt_width(MAX_OUTSTANDING);

   // Storage and state
   logic [31:0]      mem_q [DEPTH];
   logic             err_q [DEPTH];
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic [OUT_W-1:0] out_q,  out_d;
   logic [OUT_W-1:0] drop_q, drop_d;

   logic fifo_empty;
   logic accept;       // response kept for the current stream
   logic pop_eff;      // aligner really takes a word
   logic pop_stored;   // the taken word came from storage
   logic write_en;     // accepted response goes into storage

   assign fifo_empty = (cnt_q == '0);
   assign accept     = resp_valid_i && (drop_q == '0) && !branch_i;

   // ---------------------------------------------------------------------------
   // Output side: head entry when holding data, otherwise bypass the response.
   // Bypass data is gated by accept so idle outputs stay at zero.
   // ---------------------------------------------------------------------------
   always_comb begin
      fetch_valid_o = 1'b0;
      fetch_rdata_o = '0;
      fetch_err_o   = 1'b0;
      if (!fifo_empty) begin
         fetch_valid_o = !branch_i;
         fetch_rdata_o = mem_q[rptr_q];
         fetch_err_o   = err_q[rptr_q];
      end else if (accept) begin
         fetch_valid_o = 1'b1;
         fetch_rdata_o = resp_rdata_i;
         fetch_err_o   = resp_err_i;
      end
   end

   assign pop_eff    = pop_i && fetch_valid_o;
   assign pop_stored = pop_eff && !fifo_empty;
   // A response consumed straight through the bypass is never stored.
   assign write_en   = accept && !(fifo_empty && pop_i);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      drop_d = drop_q;

      // Pointers wrap naturally since DEPTH is a power of two.
      if (write_en)   wptr_d = wptr_q + 1'b1;
      if (pop_stored) rptr_d = rptr_q + 1'b1;

      if (write_en && !pop_stored)      cnt_d = cnt_q + 1'b1;
      else if (!write_en && pop_stored) cnt_d = cnt_q - 1'b1;

      // Every response retires one outstanding transaction, kept or dropped.
      if (trans_issued_i && !resp_valid_i)      out_d = out_q + 1'b1;
      else if (!trans_issued_i && resp_valid_i) out_d = out_q - 1'b1;

      if (resp_valid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;

      if (branch_i) begin
         rptr_d = '0;
         wptr_d = '0;
         cnt_d  = '0;
         // Only requests issued before this cycle belong to the old stream;
         // a response arriving now already retires one of them.
         drop_d = out_q - OUT_W'(resp_valid_i);
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
         out_q  <= '0;
         drop_q <= '0;
      end else begin
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
            err_q[i] <= 1'b0;
         end
      end else if (write_en) begin
         mem_q[wptr_q] <= resp_rdata_i;
         err_q[wptr_q] <= resp_err_i;
      end
   end

   // Limit in-flight plus buffered words so every kept response has a slot.
   always_comb begin
      req_allowed_o = (int'(out_q) < MAX_OUTSTANDING) &&
                      ((int'(cnt_q) + int'(out_q) - int'(drop_q)) < DEPTH);
   end

   // ---------------------------------------------------------------------------
   // Protocol checks
   // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(accept && (cnt_q == CNT_W'(DEPTH)) && !pop_stored))
            else $error("instr_fifo: response accepted while full");
         assert (!(resp_valid_i && (out_q == '0) && !trans_issued_i))
            else $error("instr_fifo: response without outstanding request");
      end
   end
`endif

endmodule : cv32e40p_instr_fifo

// File: tb/tb_cv32e40p_instr_fifo.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_instr_fifo
// Directed bench for the instruction prefetch FIFO at DEPTH=2,
// MAX_OUTSTANDING=2. Inputs change 1 time unit after a rising edge;
// combinational outputs are checked 1 unit later, registered state 1 unit
// after the following rising edge.
// -----------------------------------------------------------------------------
module tb_cv32e40p_instr_fifo;

  logic        clk;
  logic        rst_n;
  logic        branch_i;
  logic        trans_issued_i;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;
  logic        resp_err_i;
  logic        req_allowed_o;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic        fetch_err_o;
  logic        pop_i;

  int vectors;
  int miscompares;

  cv32e40p_instr_fifo #(
    .DEPTH          (2),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_i      (branch_i),
    .trans_issued_i(trans_issued_i),
    .resp_valid_i  (resp_valid_i),
    .resp_rdata_i  (resp_rdata_i),
    .resp_err_i    (resp_err_i),
    .req_allowed_o (req_allowed_o),
    .fetch_valid_o (fetch_valid_o),
    .fetch_rdata_o (fetch_rdata_o),
    .fetch_err_o   (fetch_err_o),
    .pop_i         (pop_i)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic br, input logic iss, input logic rv,
                       input logic [31:0] rd, input logic re, input logic pp);
    branch_i       = br;
    trans_issued_i = iss;
    resp_valid_i   = rv;
    resp_rdata_i   = rd;
    resp_err_i     = re;
    pop_i          = pp;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // advance to 1 unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input int outs, input int drop);
    chk({tag, ".cnt"},  32'(dut.cnt_q),  32'(cnt));
    chk({tag, ".out"},  32'(dut.out_q),  32'(outs));
    chk({tag, ".drop"}, 32'(dut.drop_q), 32'(drop));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    idle();

    // ---- reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(fetch_valid_o), 32'd0);
    chk("rst.rdata", fetch_rdata_o, 32'h0);
    chk("rst.err",   32'(fetch_err_o), 32'd0);
    chk("rst.allow", 32'(req_allowed_o), 32'd1);
    chk_state("rst", 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // ---- zero-latency bypass with pop
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_state("byp.issue", 0, 1, 0);
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1);
    #1;
    chk("byp.valid", 32'(fetch_valid_o), 32'd1);
    chk("byp.rdata", fetch_rdata_o, 32'h0000_0013);
    chk("byp.err",   32'(fetch_err_o), 32'd0);
    tick();
    chk_state("byp.after", 0, 0, 0);

    // ---- fill to full, then drain in order (second word carries an error)
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("fill.allow1", 32'(req_allowed_o), 32'd1);
    tick();
    chk("fill.allow2", 32'(req_allowed_o), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    #1;
    chk("fill.a.valid", 32'(fetch_valid_o), 32'd1);
    chk("fill.a.rdata", fetch_rdata_o, 32'h1111_1111);
    tick();
    chk_state("fill.a", 1, 1, 0);
    drive(1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0);
    #1;
    chk("fill.head.rdata", fetch_rdata_o, 32'h1111_1111);
    chk("fill.head.err",   32'(fetch_err_o), 32'd0);
    tick();
    chk_state("fill.full", 2, 0, 0);
    chk("fill.full.allow", 32'(req_allowed_o), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    chk("drain.a.rdata", fetch_rdata_o, 32'h1111_1111);
    chk("drain.a.err",   32'(fetch_err_o), 32'd0);
    tick();
    chk("drain.cnt1", 32'(dut.cnt_q), 32'd1);
    chk("drain.b.rdata", fetch_rdata_o, 32'h2222_2222);
    chk("drain.b.err",   32'(fetch_err_o), 32'd1);
    tick();
    chk("drain.cnt0",  32'(dut.cnt_q), 32'd0);
    chk("drain.allow", 32'(req_allowed_o), 32'd1);
    chk("drain.valid", 32'(fetch_valid_o), 32'd0);

    // ---- stray pop while nothing is valid is ignored
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    chk_state("stray.pop", 0, 0, 0);
    chk("stray.rptr", 32'(dut.rptr_q), 32'd0);

    // ---- branch with two outstanding: next two responses dropped
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk_state("br.pre", 0, 2, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("br.valid", 32'(fetch_valid_o), 32'd0);
    tick();
    chk_state("br.post", 0, 2, 2);
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_0001, 1'b0, 1'b1);
    #1;
    chk("drop1.valid", 32'(fetch_valid_o), 32'd0);
    tick();
    chk_state("drop1", 0, 1, 1);
    // new-stream request issued alongside the second stale response
    drive(1'b0, 1'b1, 1'b1, 32'hDEAD_0002, 1'b0, 1'b1);
    #1;
    chk("drop2.valid", 32'(fetch_valid_o), 32'd0);
    tick();
    chk_state("drop2", 0, 1, 0);
    drive(1'b0, 1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b1);
    #1;
    chk("third.valid", 32'(fetch_valid_o), 32'd1);
    chk("third.rdata", fetch_rdata_o, 32'h3333_3333);
    chk("third.err",   32'(fetch_err_o), 32'd1);
    tick();
    chk_state("third", 0, 0, 0);

    // ---- branch together with response and new issue, out=1
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_0003, 1'b0, 1'b1);
    #1;
    chk("brx.valid", 32'(fetch_valid_o), 32'd0);
    tick();
    chk_state("brx", 0, 1, 0);
    drive(1'b0, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b0);
    #1;
    chk("brx.d.valid", 32'(fetch_valid_o), 32'd1);
    chk("brx.d.rdata", fetch_rdata_o, 32'h4444_4444);
    tick();
    chk_state("brx.d", 1, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("brx.cnt0", 32'(dut.cnt_q), 32'd0);

    // ---- reset mid-drop
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_0004, 1'b0, 1'b0);
    tick();
    chk_state("mdrop.pre", 0, 1, 1);
    idle();
    rst_n = 1'b0;
    #1;
    chk_state("mdrop.rst", 0, 0, 0);
    chk("mdrop.allow", 32'(req_allowed_o), 32'd1);
    chk("mdrop.valid", 32'(fetch_valid_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // no residual drop: next response is presented
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b1);
    #1;
    chk("mdrop.f.valid", 32'(fetch_valid_o), 32'd1);
    chk("mdrop.f.rdata", fetch_rdata_o, 32'h5555_5555);
    tick();

    // ---- reset mid-fill
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h6666_6666, 1'b0, 1'b0);
    tick();
    chk_state("mfill.pre", 1, 0, 0);
    idle();
    rst_n = 1'b0;
    #1;
    chk_state("mfill.rst", 0, 0, 0);
    chk("mfill.valid", 32'(fetch_valid_o), 32'd0);
    chk("mfill.rdata", fetch_rdata_o, 32'h0);
    chk("mfill.allow", 32'(req_allowed_o), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_cv32e40p_instr_fifo
